// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, RAM handshake status, and the
// memory arbiter's state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE,
        DACC,
        IACC,
        DRSP,
        IRSP
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises instruction fetches and data accesses onto one single-ported RAM.
// Data has priority; each access returns a one-cycle hit with registered load data.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    input  logic              dmemREN,
    input  logic              dmemWEN,
    input  logic [WORD_W-1:0] dmemaddr,
    input  logic [WORD_W-1:0] dmemstore,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              dhit,
    output logic [WORD_W-1:0] dmemload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  ramstate_t         ramstate,
    output logic              memerr
);

    arb_state_t        r_state, w_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic              r_wr, w_wr_next;
    logic              w_latch_d, w_latch_i, w_capture, w_set_err;
    logic [WORD_W-1:0] r_addr, r_store, r_iload, r_dload;
    logic              r_ren, r_wen, r_ihit, r_dhit, r_memerr;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_wr_next  = r_wr;
        w_latch_d  = 1'b0;
        w_latch_i  = 1'b0;
        w_capture  = 1'b0;
        w_set_err  = 1'b0;
        case (r_state)
            IDLE: begin
                // REN+WEN together resolves to a write
                if (dmemREN || dmemWEN) begin
                    w_latch_d = 1'b1;
                    w_wr_next = dmemWEN;
                    w_next    = DACC;
                end else if (imemREN) begin
                    w_latch_i = 1'b1;
                    w_next    = IACC;
                end
            end
            DACC, IACC: begin
                w_cnt_next = '0;
                if (ramstate == ACCESS) begin
                    w_capture = 1'b1;
                    if (r_state == DACC) w_next = DRSP;
                    else                 w_next = IRSP;
                end else if (ramstate == ERROR) begin
                    w_set_err = 1'b1;
                    w_next    = IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_set_err = 1'b1;
                    w_next    = IDLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            DRSP, IRSP: w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_store  <= '0;
            r_iload  <= '0;
            r_dload  <= '0;
            r_ren    <= 1'b0;
            r_wen    <= 1'b0;
            r_ihit   <= 1'b0;
            r_dhit   <= 1'b0;
            r_memerr <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_wr     <= w_wr_next;
            // Enables and hits are decoded from the next state so they line up with it
            r_ren    <= (w_next == IACC) || ((w_next == DACC) && !w_wr_next);
            r_wen    <= (w_next == DACC) && w_wr_next;
            r_ihit   <= (w_next == IRSP);
            r_dhit   <= (w_next == DRSP);
            r_memerr <= r_memerr | w_set_err;
            if (w_latch_d) begin
                r_addr  <= dmemaddr;
                r_store <= dmemstore;
            end else if (w_latch_i) begin
                r_addr <= imemaddr;
            end
            if (w_capture) begin
                if (r_state == IACC)  r_iload <= ramload;
                else if (!r_wr)       r_dload <= ramload;
            end
        end
    end

    assign ihit     = r_ihit;
    assign dhit     = r_dhit;
    assign imemload = r_iload;
    assign dmemload = r_dload;
    assign ramREN   = r_ren;
    assign ramWEN   = r_wen;
    assign ramaddr  = r_addr;
    assign ramstore = r_store;
    assign memerr   = r_memerr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expected load words are queued when a read
// is issued and popped when the matching hit pulse appears.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int W  = 32;
    localparam int TO = 20;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          imemREN, dmemREN, dmemWEN;
    logic [W-1:0]  imemaddr, dmemaddr, dmemstore, ramload;
    ramstate_t     ramstate;
    logic          ihit, dhit, ramREN, ramWEN, memerr;
    logic [W-1:0]  imemload, dmemload, ramaddr, ramstore;

    int            n_checks = 0;
    int            n_err    = 0;
    logic [W-1:0]  exp_q[$];

    mem_arbiter #(.WORD_W(W), .TIMEOUT(TO), .CNT_W(5)) dut (
        .CLK(CLK), .nRST(nRST),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .ihit(ihit), .imemload(imemload), .dhit(dhit), .dmemload(dmemload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    // Waits (bounded) for a hit, checks its latency and exclusivity, and pops the
    // scoreboard when the access was a read.
    task automatic wait_hit(input string tag, input bit want_d, input bit is_read,
                            input int exp_lat, input int budget);
        int   n;
        logic hit;
        n = 0;
        do begin
            cyc();
            n++;
            hit = want_d ? dhit : ihit;
        end while (!hit && n < budget);
        check({tag, "_hit"}, hit, 1);
        if (hit) begin
            check({tag, "_lat"}, n, exp_lat);
            check({tag, "_other_hit"}, want_d ? ihit : dhit, 0);
            check({tag, "_en_off"}, {ramREN, ramWEN}, 0);
            if (is_read && exp_q.size() > 0) begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check({tag, "_load"}, want_d ? dmemload : imemload, e);
            end
        end
        ramstate = FREE;
    endtask

    initial begin
        nRST = 1'b0; imemREN = 0; dmemREN = 0; dmemWEN = 0;
        imemaddr = '0; dmemaddr = '0; dmemstore = '0; ramload = '0; ramstate = FREE;
        cyc(); cyc();
        check("rst_ctrl", {ihit, dhit, ramREN, ramWEN, memerr}, 0);
        check("rst_ramaddr", ramaddr, 0);
        check("rst_ramstore", ramstore, 0);
        check("rst_imemload", imemload, 0);
        check("rst_dmemload", dmemload, 0);
        nRST = 1'b1;
        cyc();

        // Fetch with two BUSY cycles, ACCESS at cycle 3, ihit at cycle 4
        imemREN = 1; imemaddr = 32'h100; ramstate = BUSY;
        exp_q.push_back(32'h8C220004);
        cyc();
        check("f_ren", ramREN, 1);
        check("f_addr", ramaddr, 32'h100);
        check("f_wen", ramWEN, 0);
        imemREN = 0;
        cyc();
        check("f_busy_ren", ramREN, 1);
        cyc();
        ramstate = ACCESS; ramload = 32'h8C220004;
        wait_hit("fetch", 1'b0, 1'b1, 1, 4);
        check("f_dhit", dhit, 0);
        cyc();
        check("f_idle", {ihit, ramREN}, 0);

        // Simultaneous fetch and data read: data wins, fetch waits while dmemREN high
        imemREN = 1; imemaddr = 32'h400; dmemREN = 1; dmemaddr = 32'h200;
        exp_q.push_back(32'h12345678);
        cyc();
        check("p_addr", ramaddr, 32'h200);
        check("p_en", {ramREN, ramWEN}, 2'b10);
        ramstate = ACCESS; ramload = 32'h12345678;
        wait_hit("prio_d1", 1'b1, 1'b1, 1, 4);
        cyc();
        check("p_idle_en", ramREN, 0);
        cyc();
        check("p_again_data", ramaddr, 32'h200);
        dmemREN = 0; ramstate = ACCESS; ramload = 32'hCAFEF00D;
        exp_q.push_back(32'hCAFEF00D);
        wait_hit("prio_d2", 1'b1, 1'b1, 1, 4);
        cyc();
        check("p_idle2", {ramREN, ihit}, 0);
        exp_q.push_back(32'h0BADF00D);
        cyc();
        check("p_fetch_addr", ramaddr, 32'h400);
        check("p_fetch_ren", ramREN, 1);
        imemREN = 0; ramstate = ACCESS; ramload = 32'h0BADF00D;
        wait_hit("prio_i", 1'b0, 1'b1, 1, 4);
        cyc();

        // Write; store data changes mid-access but the latched word is driven
        dmemWEN = 1; dmemaddr = 32'h300; dmemstore = 32'hDEADBEEF; ramstate = BUSY;
        cyc();
        check("w_en", {ramREN, ramWEN}, 2'b01);
        check("w_addr", ramaddr, 32'h300);
        check("w_store", ramstore, 32'hDEADBEEF);
        dmemWEN = 0; dmemstore = 32'h11111111;
        cyc();
        check("w_store_held", ramstore, 32'hDEADBEEF);
        check("w_en2", {ramREN, ramWEN}, 2'b01);
        ramstate = ACCESS;
        wait_hit("write", 1'b1, 1'b0, 1, 4);
        cyc();

        // ERROR during fetch: memerr set, no hit, request retried
        imemREN = 1; imemaddr = 32'h500; ramstate = BUSY;
        cyc();
        check("e_ren", ramREN, 1);
        check("e_memerr0", memerr, 0);
        ramstate = ERROR;
        cyc();
        check("e_memerr1", memerr, 1);
        check("e_nohit", {ihit, ramREN}, 0);
        ramstate = FREE;
        exp_q.push_back(32'h55AA55AA);
        cyc();
        check("e_retry_ren", ramREN, 1);
        imemREN = 0; ramstate = ACCESS; ramload = 32'h55AA55AA;
        wait_hit("retry", 1'b0, 1'b1, 1, 4);
        check("e_memerr_sticky", memerr, 1);
        cyc();

        // Asynchronous reset in the middle of a data access
        dmemREN = 1; dmemaddr = 32'h600; ramstate = BUSY;
        cyc();
        check("r_ren_pre", ramREN, 1);
        #2 nRST = 1'b0;
        #1;
        check("r_async", {ramREN, ramWEN, dhit, memerr}, 0);
        dmemREN = 0; ramstate = FREE;
        cyc();
        nRST = 1'b1;
        cyc();

        // Fresh access after reset; REN and WEN together behave as a write
        dmemREN = 1; dmemWEN = 1; dmemaddr = 32'h700; dmemstore = 32'hA5A5A5A5; ramstate = ACCESS;
        cyc();
        check("b_en", {ramREN, ramWEN}, 2'b01);
        check("b_store", ramstore, 32'hA5A5A5A5);
        dmemREN = 0; dmemWEN = 0;
        wait_hit("both", 1'b1, 1'b0, 1, 4);
        cyc();

        // Timeout: TO BUSY cycles in IACC abandons the access
        imemREN = 1; imemaddr = 32'h800; ramstate = BUSY;
        cyc();
        imemREN = 0;
        for (int i = 2; i <= TO; i++) begin
            cyc();
            if (i == TO) begin
                check("t_last_ren", ramREN, 1);
                check("t_last_err", memerr, 0);
            end
        end
        cyc();
        check("t_ren_drop", ramREN, 0);
        check("t_memerr", memerr, 1);
        check("t_nohit", ihit, 0);

        // Counter restarts: TO-1 BUSY cycles then ACCESS still completes
        imemREN = 1; imemaddr = 32'h900;
        cyc();
        imemREN = 0;
        for (int i = 2; i <= TO - 1; i++) cyc();
        cyc();
        check("t2_ren", ramREN, 1);
        exp_q.push_back(32'h600DD00D);
        ramstate = ACCESS; ramload = 32'h600DD00D;
        wait_hit("after_to", 1'b0, 1'b1, 1, 4);
        check("t2_memerr", memerr, 1);
        check("q_empty", exp_q.size(), 0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
